// File: rtl/dyt_sram_ctrl_pkg.sv
// Shared types for the SRAM-side responder: data word, controller FSM states, defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dyt_sram_ctrl_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } sram_state_t;

  localparam int SRAM_ADDR_W_DEF = 12;
  localparam int SRAM_MAX_LAT    = 4;

endpackage

// File: rtl/dyt_sram_bram.sv
// Inferred single-port block RAM: synchronous write, one registered read stage.
// Latency: 1 cycle from address to rdata; writes commit at the clock edge.
// Backpressure: none; it accepts an access every cycle.
module dyt_sram_bram
  import dyt_sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  word_t             wdata,
  output word_t             rdata
);

  word_t mem [0:(1 << ADDR_W) - 1];

  // Plain read-first template so synthesis maps it onto a block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dyt_sram_ctrl.sv
// SRAM-side responder: FSM, range check, sticky error and busy/rvalid around an inferred BRAM.
// Latency: writes take 1 cycle; reads deliver rvalid exactly READ_LAT cycles after acceptance.
// Backpressure: sram_busy stalls the CPU from read acceptance until the cycle before DONE.
module dyt_sram_ctrl
  import dyt_sram_ctrl_pkg::*;
#(
  parameter int ADDR_W   = SRAM_ADDR_W_DEF,
  parameter int READ_LAT = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  word_t sram_address,
  input  word_t sram_w_data,
  input  logic  sram_ren,
  input  logic  sram_wen,
  output word_t sram_r_data,
  output logic  sram_busy,
  output logic  sram_rvalid,
  output logic  sram_err
);

  if (READ_LAT < 1 || READ_LAT > SRAM_MAX_LAT) begin : g_bad_lat
    $error("dyt_sram_ctrl: READ_LAT must be within 1..%0d", SRAM_MAX_LAT);
  end

  localparam logic [2:0] CNT_LOAD = 3'(READ_LAT - 1);

  sram_state_t       state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q;
  logic              oor_q;
  word_t             r_hold_q;
  word_t             bram_rdata;
  logic              err_q;

  logic [ADDR_W-1:0] req_idx;
  logic              in_range;
  logic              is_idle;
  logic              wr_fire;
  logic              rd_acc;
  logic              bad_req;
  logic              unused_addr_lsb;

  // Byte offset bits carry no meaning for a word-wide RAM.
  assign unused_addr_lsb = ^sram_address[1:0];

  assign req_idx  = sram_address[ADDR_W+1:2];
  assign in_range = ((sram_address >> (ADDR_W + 2)) == '0);
  assign is_idle  = (state_q == IDLE);
  assign wr_fire  = is_idle && sram_wen && in_range;
  assign rd_acc   = is_idle && sram_ren && !sram_wen;
  assign bad_req  = is_idle && ((sram_ren && sram_wen) ||
                                ((sram_ren || sram_wen) && !in_range));

  // During WAIT the BRAM keeps reading the latched index so its output stays valid until DONE.
  dyt_sram_bram #(.ADDR_W(ADDR_W)) u_bram (
    .clk   (clk),
    .we    (wr_fire && !rst),
    .addr  (is_idle ? req_idx : idx_q),
    .wdata (sram_w_data),
    .rdata (bram_rdata)
  );

  // Next-state: accept reads in IDLE, count down in WAIT, single-cycle DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (rd_acc) begin
          cnt_d   = CNT_LOAD;
          state_d = (READ_LAT == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_d == 3'd0) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched request, held read data and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      idx_q    <= '0;
      oor_q    <= 1'b0;
      r_hold_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (rd_acc) begin
        idx_q <= req_idx;
        oor_q <= !in_range;
      end
      if (state_q == DONE) begin
        r_hold_q <= sram_r_data;
      end
      if (bad_req) begin
        err_q <= 1'b1;
      end
    end
  end

  assign sram_busy   = rd_acc || (state_q == WAIT);
  assign sram_rvalid = (state_q == DONE);
  assign sram_err    = err_q;
  // Out-of-range reads still run the full latency but return zero.
  assign sram_r_data = (state_q == DONE) ? (oor_q ? '0 : bram_rdata) : r_hold_q;

endmodule
